// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed seven-segment display driver:
// blanking patterns, digit count and the hex-to-segment pattern table.
package hex_display_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = $clog2(DIGITS);

    // Active-low "everything off" patterns.
    localparam logic [6:0]        SEG_OFF = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry 0 is the LSB slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Resolved write action after clear > load > shift priority.
    typedef enum logic [1:0] {
        WR_NONE,
        WR_CLEAR,
        WR_LOAD,
        WR_SHIFT
    } wr_op_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display_driver.sv
// Four-digit time-multiplexed common-anode display driver. Writes land in a
// shadow register and are copied to the displayed value only at a frame
// boundary, so a frame never shows a mix of old and new digits.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        shift_en,
    input  logic [3:0]  digit_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] shown,
    output logic        commit
);

    localparam int                PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]     GUARD_CNT  = PW'(GUARD);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DIGITS - 1);

    logic [PW-1:0]      prescaler_q, prescaler_d;
    logic [DIGIT_W-1:0] digit_idx_q, digit_idx_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [15:0]        shown_q, shown_d;
    logic               pending_q, pending_d;
    logic               commit_q, commit_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic               slot_wrap;
    logic               frame_end;
    wr_op_e             wr_op;
    logic [3:0]         cur_nibble;
    logic [6:0]         cur_pattern;
    logic [DIGITS-1:0]  lz_blank;
    logic               lz_run;
    logic               lit;

    assign slot_wrap = (prescaler_q == PRESC_LAST);
    assign frame_end = slot_wrap && (digit_idx_q == LAST_DIGIT);

    // Slot timing: prescaler wraps each slot, digit index steps on every wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        prescaler_d = prescaler_q + PW'(1);
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            prescaler_d = '0;
            digit_idx_d = digit_idx_q + DIGIT_W'(1);
        end
    end

    // Resolve simultaneous write strobes into a single action.
    always_comb begin
        wr_op = WR_NONE;
        if (clear) begin
            wr_op = WR_CLEAR;
        end else if (load) begin
            wr_op = WR_LOAD;
        end else if (shift_en) begin
            wr_op = WR_SHIFT;
        end
    end

    // Shadow update and frame-boundary commit; a same-cycle write stays pending for the next frame.
    always_comb begin
        shadow_d  = shadow_q;
        shown_d   = shown_q;
        pending_d = pending_q;
        commit_d  = 1'b0;
        unique case (wr_op)
            WR_CLEAR: shadow_d = '0;
            WR_LOAD:  shadow_d = data_in;
            WR_SHIFT: shadow_d = {shadow_q[11:0], digit_in};
            default:  shadow_d = shadow_q;
        endcase
        if (frame_end && pending_q) begin
            shown_d   = shadow_q;
            pending_d = 1'b0;
            commit_d  = 1'b1;
        end
        if (wr_op != WR_NONE) begin
            pending_d = 1'b1;
        end
    end

    // Leading-zero mask: digit k is blank while it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && (shown_q[4*k +: 4] == 4'h0);
            lz_blank[k] = lz_run;
        end
    end

    assign cur_nibble = shown_q[{digit_idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_pattern)
    );

    // Next anode/segment values: dark during the guard window, when disabled, or for a blanked digit.
    always_comb begin
        lit   = enable && (prescaler_q >= GUARD_CNT) && !lz_blank[digit_idx_q];
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (lit) begin
            an_d  = ~(4'(1) << digit_idx_q);
            seg_d = cur_pattern;
        end
    end

    // State registers; all clear asynchronously so the display goes dark the moment reset asserts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            shadow_q    <= '0;
            shown_q     <= '0;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            shadow_q    <= shadow_d;
            shown_q     <= shown_d;
            pending_q   <= pending_d;
            commit_q    <= commit_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign shown  = shown_q;
    assign commit = commit_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench for hex_display_driver with REFRESH_DIV=4, GUARD=1.
// Stimulus pushes expected commits and expected lit slots into queues; a
// monitor pops them when the DUT pulses commit or lights a new digit slot.
module tb_hex_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        blank_lz = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic        shift_en = 1'b0;
    logic [3:0]  digit_in = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] shown;
    logic        commit;

    int errors = 0;
    int checks = 0;
    int n;                          // clock edges since reset release

    logic [15:0] exp_commit_q[$];
    logic [10:0] exp_slot_q[$];     // {an, seg} for each lit slot, in order

    hex_display_driver #(.REFRESH_DIV(4), .GUARD(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .blank_lz (blank_lz),
        .clear    (clear),
        .load     (load),
        .data_in  (data_in),
        .shift_en (shift_en),
        .digit_in (digit_in),
        .seg      (seg),
        .an       (an),
        .shown    (shown),
        .commit   (commit)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic wait_n(input int target);
        while (n < target) @(negedge clk);
        check("schedule", n, target);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; data_in = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_shift(input logic [3:0] d);
        shift_en = 1'b1; digit_in = d;
        @(negedge clk);
        shift_en = 1'b0;
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [6:0] s);
        exp_slot_q.push_back({a, s});
    endtask

    // Monitor: commit scoreboard, guard-window check, slot position and slot content scoreboard.
    logic        prev_lit = 1'b0;
    logic        have_cur = 1'b0;
    logic [10:0] cur_exp  = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (commit) begin
                if (exp_commit_q.size() == 0) begin
                    check("commit_unexpected", {16'h0, shown}, 32'hFFFF_FFFF);
                end else begin
                    check("commit_value", shown, exp_commit_q.pop_front());
                end
                check("commit_timing", n % 16, 0);
            end
            if (n >= 1 && (n % 4) == 1) check("guard_dark", an, 4'hF);
            if (an != 4'hF) begin
                automatic int d = ((n - 1) / 4) % 4;
                automatic logic [3:0] pos = ~(4'b0001 << d);
                check("an_position", an, pos);
                if (!prev_lit) begin
                    have_cur = (exp_slot_q.size() != 0);
                    if (have_cur) cur_exp = exp_slot_q.pop_front();
                end
                if (have_cur) check("slot_an_seg", {an, seg}, cur_exp);
            end else begin
                have_cur = 1'b0;
            end
            prev_lit = (an != 4'hF);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_shown", shown, 16'h0);
        check("rst_commit", commit, 1'b0);
        rst = 1'b1;

        // Parallel load, committed at the first frame boundary.
        exp_commit_q.push_back(16'h12AF);
        do_load(16'h12AF);
        wait_n(17);
        push_slot(4'hE, 7'h0E); push_slot(4'hD, 7'h08);
        push_slot(4'hB, 7'h24); push_slot(4'h7, 7'h79);

        // Clear then shift 1,2,3,4; shown holds until the boundary.
        wait_n(34);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        exp_commit_q.push_back(16'h1234);
        for (int i = 1; i <= 4; i++) do_shift(4'(i));
        wait_n(40);
        check("shown_hold", shown, 16'h12AF);
        wait_n(50);
        exp_commit_q.push_back(16'h2345);
        do_shift(4'h5);

        // Leading-zero blanking.
        wait_n(66);
        exp_commit_q.push_back(16'h0050);
        do_load(16'h0050);
        wait_n(81);
        blank_lz = 1'b1;
        push_slot(4'hE, 7'h40); push_slot(4'hD, 7'h12);
        push_slot(4'hE, 7'h40); push_slot(4'hD, 7'h12);
        wait_n(97);
        exp_commit_q.push_back(16'h0000);
        do_load(16'h0000);
        wait_n(113);
        push_slot(4'hE, 7'h40); push_slot(4'hE, 7'h40);

        // Simultaneous clear, load and shift: clear wins.
        wait_n(145);
        blank_lz = 1'b0;
        clear = 1'b1; load = 1'b1; data_in = 16'h9999; shift_en = 1'b1; digit_in = 4'h7;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; shift_en = 1'b0;
        exp_commit_q.push_back(16'h0000);

        // Load in the boundary cycle: old shadow commits now, new one a frame later.
        wait_n(162);
        exp_commit_q.push_back(16'h1111);
        do_load(16'h1111);
        wait_n(175);
        exp_commit_q.push_back(16'hA5A5);
        do_load(16'hA5A5);
        wait_n(177);
        check("boundary_old", shown, 16'h1111);

        // Display disabled for a frame while a load is pending.
        wait_n(193);
        enable = 1'b0;
        exp_commit_q.push_back(16'h0F0F);
        do_load(16'h0F0F);
        for (int i = 0; i < 16; i++) begin
            check("disabled_an", an, 4'hF);
            check("disabled_seg", seg, 7'h7F);
            @(negedge clk);
        end
        enable = 1'b1;
        wait_n(225);
        push_slot(4'hE, 7'h0E); push_slot(4'hD, 7'h40);
        push_slot(4'hB, 7'h0E); push_slot(4'h7, 7'h40);

        // Reset in the middle of the digit-2 slot.
        wait_n(249);
        rst = 1'b0;
        #1;
        check("midrst_seg", seg, 7'h7F);
        check("midrst_an", an, 4'hF);
        check("midrst_shown", shown, 16'h0);
        check("midrst_commit", commit, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (an != 4'hF);
        end
        if (!found) begin
            check("first_lit_timeout", 32'd0, 32'd1);
        end else begin
            check("first_lit_edge", n, 2);
            check("first_lit_an", an, 4'hE);
            check("first_lit_seg", seg, 7'h40);
        end

        repeat (8) @(negedge clk);
        check("commit_queue_drained", exp_commit_q.size(), 0);
        check("slot_queue_drained", exp_slot_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
